// File: rtl/lcd_window_sched.sv
// lcd_window_sched: places up to three ROM-backed picture windows on the LCD raster.
// Each window's ROM address is prefetched far enough ahead to cover the read latency.
// Where windows overlap, the lowest-numbered enabled window supplies the pixel.
module lcd_window_sched #(
    parameter int          PIC_WIDTH  = 250,
    parameter int          PIC_HEIGHT = 114,
    parameter int          Y_START    = 10,
    parameter int          X_START0   = 10,
    parameter int          X_START1   = 270,
    parameter int          X_START2   = 540,
    parameter int          RD_LAT     = 1,
    parameter logic [23:0] BACK_COLOR = 24'hE0FFFF
) (
    input  logic        lcd_pclk,
    input  logic        rstn,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic [2:0]  win_en,
    input  logic [23:0] rom_data0,
    input  logic [23:0] rom_data1,
    input  logic [23:0] rom_data2,
    output logic [14:0] rom_addr0,
    output logic [14:0] rom_addr1,
    output logic [14:0] rom_addr2,
    output logic [23:0] pixel_data,
    output logic        frame_done,
    output logic [2:0]  en_active
);
    localparam logic [14:0] NPIX = 15'(PIC_WIDTH * PIC_HEIGHT);
    localparam logic [11:0] Y0   = 12'(Y_START);
    localparam logic [11:0] Y1   = 12'(Y_START + PIC_HEIGHT);
    localparam logic [35:0] XS   = {12'(X_START2), 12'(X_START1), 12'(X_START0)};

    typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_DONE} state_t;

    state_t      r_state;
    logic [14:0] r_addr [3];
    logic [23:0] r_pix;
    logic        r_done;
    logic [2:0]  r_en;
    logic [11:0] w_y;
    logic [11:0] w_x_pix;
    logic [11:0] w_x_pre;
    logic [2:0]  w_hit_pix;
    logic [2:0]  w_hit_pre;
    logic [23:0] w_pix;

    // Coordinates widened to 12 bits so x + offset never wraps
    assign w_y     = {1'b0, pixel_ypos};
    assign w_x_pix = {1'b0, pixel_xpos} + 12'd1;
    assign w_x_pre = {1'b0, pixel_xpos} + 12'(RD_LAT + 1);

    // Enabled-window hit tests for the next displayed pixel and for the prefetch column
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_hit_pix[k] = r_en[k] && w_y >= Y0 && w_y < Y1 &&
                           w_x_pix >= XS[12*k +: 12] && w_x_pix < XS[12*k +: 12] + 12'(PIC_WIDTH);
            w_hit_pre[k] = r_en[k] && w_y >= Y0 && w_y < Y1 &&
                           w_x_pre >= XS[12*k +: 12] && w_x_pre < XS[12*k +: 12] + 12'(PIC_WIDTH);
        end
    end

    assign w_pix = w_hit_pix[0] ? rom_data0 :
                   w_hit_pix[1] ? rom_data1 :
                   w_hit_pix[2] ? rom_data2 : BACK_COLOR;

    // Frame FSM: latches enables before the window rows, counts addresses during them, clears after
    always_ff @(posedge lcd_pclk) begin
        if (!rstn) begin
            r_state <= S_WAIT;
            r_en    <= '0;
            r_done  <= 1'b0;
            r_pix   <= BACK_COLOR;
            for (int k = 0; k < 3; k++) r_addr[k] <= '0;
        end else begin
            r_done <= 1'b0;
            r_pix  <= BACK_COLOR;
            case (r_state)
                S_WAIT: begin
                    r_en <= win_en;
                    if (w_y == Y0) r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    r_pix <= w_pix;
                    for (int k = 0; k < 3; k++)
                        if (w_hit_pre[k] && r_addr[k] != NPIX) r_addr[k] <= r_addr[k] + 15'd1;
                    if (w_y < Y0) begin
                        r_state <= S_WAIT;
                        for (int k = 0; k < 3; k++) r_addr[k] <= '0;
                    end else if (w_y >= Y1) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    for (int k = 0; k < 3; k++) r_addr[k] <= '0;
                    if (w_y < Y0) begin
                        r_state <= S_WAIT;
                    end else if (Y_START == 0 && w_y == 12'd0) begin
                        r_state <= S_ACTIVE;
                        r_en    <= win_en;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign rom_addr0  = r_addr[0];
    assign rom_addr1  = r_addr[1];
    assign rom_addr2  = r_addr[2];
    assign pixel_data = r_pix;
    assign frame_done = r_done;
    assign en_active  = r_en;
endmodule
